// File: rtl/issue_ctl.sv
// issue_ctl: in-order issue controller for the decode -> EX/MEM/WB boundary.
// A DEPTH-entry shift-register scoreboard tracks in-flight register writes.
// A decoded instruction is held back while one of its enabled sources is
// still pending, or while the single memory port is occupied. The oldest
// entry drives the register-file write strobe/address, and stall cycles are
// counted in a saturating 16-bit performance counter.
module issue_ctl #(
   parameter int DEPTH   = 3,   // issue -> register-file write stages, 2..8
   parameter int MEM_LAT = 2    // cycles the memory port is held per op, 1..15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic        id_rden_a,
   input  logic        id_rden_b,
   input  logic        id_wren,
   input  logic [4:0]  id_rrdaddra,
   input  logic [4:0]  id_rrdaddrb,
   input  logic [4:0]  id_rwraddrd,
   input  logic        id_memen,
   input  logic        halt,
   output logic        id_ready,
   output logic        stall,
   output logic        issue,
   output logic        mem_busy,
   output logic        wb_valid,
   output logic [4:0]  wb_addr,
   output logic [15:0] hazard_cnt
);

   // Value loaded into the memory-port counter when a memory op issues;
   // the port is then busy for MEM_LAT-1 further cycles.
   localparam logic [3:0] MEM_LOAD = 4'(MEM_LAT - 1);

   // Scoreboard: index N is pipeline stage N after issue (N = DEPTH-1 is WB).
   logic [DEPTH-1:0] vld_p;
   logic [DEPTH-1:0] wren_p;
   logic [4:0]       addr_p [DEPTH];

   logic [3:0]       mem_cnt;
   logic [15:0]      hazard_cnt_q;
   logic             match_a;
   logic             match_b;
   logic             reg_hazard;
   logic             mem_hazard;

   // Saturating increment: holds at all-ones instead of wrapping to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   // Source-register match against every in-flight entry, writeback included
   // (the register file has no bypass, so a WB-stage write is still pending).
   always_comb begin
      match_a = 1'b0;
      match_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_p[i] && wren_p[i] && (addr_p[i] == id_rrdaddra)) match_a = 1'b1;
         if (vld_p[i] && wren_p[i] && (addr_p[i] == id_rrdaddrb)) match_b = 1'b1;
      end
   end

   // Hazard and handshake decode; halt gates acceptance but not stall.
   always_comb begin
      reg_hazard = (id_rden_a & match_a) | (id_rden_b & match_b);
      mem_hazard = id_memen & (mem_cnt != 4'd0);
      stall      = id_valid & (reg_hazard | mem_hazard);
      id_ready   = id_valid & ~stall & ~halt;
   end

   // Decode -> stage 0 boundary, then one-stage-per-clock shift toward WB;
   // a bubble enters stage 0 whenever nothing is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p  <= '0;
         wren_p <= '0;
         for (int i = 0; i < DEPTH; i++) addr_p[i] <= 5'd0;
      end else begin
         vld_p     <= {vld_p[DEPTH-2:0], id_ready};
         wren_p    <= {wren_p[DEPTH-2:0], id_ready & id_wren};
         addr_p[0] <= id_ready ? id_rwraddrd : 5'd0;
         for (int i = 1; i < DEPTH; i++) addr_p[i] <= addr_p[i-1];
      end
   end

   // Memory-port occupancy: reload on a memory issue, otherwise count down.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_cnt <= 4'd0;
      end else if (id_ready && id_memen) begin
         mem_cnt <= MEM_LOAD;
      end else if (mem_cnt != 4'd0) begin
         mem_cnt <= mem_cnt - 4'd1;
      end
   end

   // Performance counter of stall cycles (halt does not suppress counting).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hazard_cnt_q <= 16'd0;
      end else if (stall) begin
         hazard_cnt_q <= sat_inc16(hazard_cnt_q);
      end
   end

   // Stage 0 is the EX launch; stage DEPTH-1 is the register-file write.
   assign issue      = vld_p[0];
   assign wb_valid   = vld_p[DEPTH-1] & wren_p[DEPTH-1];
   assign wb_addr    = addr_p[DEPTH-1];
   assign mem_busy   = (mem_cnt != 4'd0);
   assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_issue_ctl.sv
// tb_issue_ctl: directed bench for issue_ctl. Main instance uses DEPTH=3,
// MEM_LAT=2; a MEM_LAT=1 instance checks back-to-back memory issue; a
// MEM_LAT=15 instance with a permanently presented memory op drives the
// stall counter into saturation.
module tb_issue_ctl;

   logic        clk;
   logic        reset;
   logic        valid, rden_a, rden_b, wren, memen, halt;
   logic [4:0]  ra, rb, rd;
   logic        ready, stall, issue, mem_busy, wb_valid;
   logic [4:0]  wb_addr;
   logic [15:0] hcnt;

   logic        m1_valid, m1_memen;
   logic        m1_ready, m1_stall, m1_issue, m1_busy, m1_wbv;
   logic [4:0]  m1_wba;
   logic [15:0] m1_hcnt;

   logic        s_reset;
   logic        s_ready, s_stall, s_issue, s_busy, s_wbv;
   logic [4:0]  s_wba;
   logic [15:0] s_hcnt;

   int total = 0;
   int bad   = 0;

   issue_ctl #(.DEPTH(3), .MEM_LAT(2)) dut (
      .clk(clk), .reset(reset), .id_valid(valid), .id_rden_a(rden_a),
      .id_rden_b(rden_b), .id_wren(wren), .id_rrdaddra(ra), .id_rrdaddrb(rb),
      .id_rwraddrd(rd), .id_memen(memen), .halt(halt), .id_ready(ready),
      .stall(stall), .issue(issue), .mem_busy(mem_busy), .wb_valid(wb_valid),
      .wb_addr(wb_addr), .hazard_cnt(hcnt)
   );

   issue_ctl #(.DEPTH(3), .MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .id_valid(m1_valid), .id_rden_a(1'b0),
      .id_rden_b(1'b0), .id_wren(1'b0), .id_rrdaddra(5'd0), .id_rrdaddrb(5'd0),
      .id_rwraddrd(5'd0), .id_memen(m1_memen), .halt(1'b0), .id_ready(m1_ready),
      .stall(m1_stall), .issue(m1_issue), .mem_busy(m1_busy), .wb_valid(m1_wbv),
      .wb_addr(m1_wba), .hazard_cnt(m1_hcnt)
   );

   issue_ctl #(.DEPTH(2), .MEM_LAT(15)) dsat (
      .clk(clk), .reset(s_reset), .id_valid(1'b1), .id_rden_a(1'b0),
      .id_rden_b(1'b0), .id_wren(1'b0), .id_rrdaddra(5'd0), .id_rrdaddrb(5'd0),
      .id_rwraddrd(5'd0), .id_memen(1'b1), .halt(1'b0), .id_ready(s_ready),
      .stall(s_stall), .issue(s_issue), .mem_busy(s_busy), .wb_valid(s_wbv),
      .wb_addr(s_wba), .hazard_cnt(s_hcnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic ea, input logic eb, input logic we,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic mem);
      valid = v; rden_a = ea; rden_b = eb; wren = we;
      ra = a; rb = b; rd = d; memen = mem;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; s_reset = 1'b0; halt = 1'b0;
      m1_valid = 1'b0; m1_memen = 1'b0;
      idle();

      // Reset state
      neg();
      chk("rst_issue", {15'd0, issue}, 16'd0);
      chk("rst_busy", {15'd0, mem_busy}, 16'd0);
      chk("rst_wbv", {15'd0, wb_valid}, 16'd0);
      chk("rst_wba", {11'd0, wb_addr}, 16'd0);
      chk("rst_hcnt", hcnt, 16'd0);
      chk("rst_ready", {15'd0, ready}, 16'd0);
      chk("rst_stall", {15'd0, stall}, 16'd0);
      nxt();
      reset = 1'b1; s_reset = 1'b1;

      // Saturation instance: issue at cycle 0, 14 stalls, issue at cycle 15
      repeat (15) nxt();
      neg();
      chk("sat_cnt15", s_hcnt, 16'd14);
      chk("sat_stall15", {15'd0, s_stall}, 16'd0);
      chk("sat_busy15", {15'd0, s_busy}, 16'd0);
      nxt();

      // Independent stream r1, r2, r3
      drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd1, 0); neg();
      chk("ind_rdy1", {15'd0, ready}, 16'd1);
      chk("ind_stall1", {15'd0, stall}, 16'd0);
      nxt(); drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd2, 0); neg();
      chk("ind_rdy2", {15'd0, ready}, 16'd1);
      chk("ind_issue", {15'd0, issue}, 16'd1);
      nxt(); drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd3, 0); neg();
      chk("ind_rdy3", {15'd0, ready}, 16'd1);
      nxt(); idle(); neg();
      chk("ind_wbv1", {15'd0, wb_valid}, 16'd1);
      chk("ind_wba1", {11'd0, wb_addr}, 16'd1);
      nxt(); neg();
      chk("ind_wbv2", {15'd0, wb_valid}, 16'd1);
      chk("ind_wba2", {11'd0, wb_addr}, 16'd2);
      nxt(); neg();
      chk("ind_wbv3", {15'd0, wb_valid}, 16'd1);
      chk("ind_wba3", {11'd0, wb_addr}, 16'd3);
      nxt(); neg();
      chk("ind_wbv_end", {15'd0, wb_valid}, 16'd0);
      chk("ind_hcnt", hcnt, 16'd0);
      nxt();

      // RAW through port A
      drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd5, 0); neg();
      chk("rawa_prod", {15'd0, ready}, 16'd1);
      nxt(); drive(1, 1, 0, 0, 5'd5, 5'd0, 5'd0, 0); neg();
      chk("rawa_st1", {15'd0, stall}, 16'd1);
      chk("rawa_rdy1", {15'd0, ready}, 16'd0);
      nxt(); neg();
      chk("rawa_st2", {15'd0, stall}, 16'd1);
      nxt(); neg();
      chk("rawa_st3", {15'd0, stall}, 16'd1);
      chk("rawa_wbv", {15'd0, wb_valid}, 16'd1);
      chk("rawa_wba", {11'd0, wb_addr}, 16'd5);
      nxt(); neg();
      chk("rawa_st4", {15'd0, stall}, 16'd0);
      chk("rawa_rdy4", {15'd0, ready}, 16'd1);
      chk("rawa_hcnt", hcnt, 16'd3);
      nxt(); idle(); neg();
      chk("rawa_issue", {15'd0, issue}, 16'd1);
      nxt(); nxt();

      // RAW through port B
      drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd5, 0);
      nxt(); drive(1, 0, 1, 0, 5'd0, 5'd5, 5'd0, 0); neg();
      chk("rawb_st1", {15'd0, stall}, 16'd1);
      nxt(); nxt(); neg();
      chk("rawb_st3", {15'd0, stall}, 16'd1);
      nxt(); neg();
      chk("rawb_rdy4", {15'd0, ready}, 16'd1);
      chk("rawb_hcnt", hcnt, 16'd6);
      nxt(); idle(); nxt(); nxt();

      // Port A address matches but port A is not read
      drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd5, 0);
      nxt(); drive(1, 0, 1, 0, 5'd5, 5'd9, 5'd0, 0); neg();
      chk("noen_stall", {15'd0, stall}, 16'd0);
      chk("noen_rdy", {15'd0, ready}, 16'd1);
      chk("noen_hcnt", hcnt, 16'd6);
      nxt(); idle(); repeat (3) nxt();

      // Memory spacing: MEM_LAT=2 instance vs MEM_LAT=1 instance
      drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd10, 1);
      m1_valid = 1'b1; m1_memen = 1'b1; neg();
      chk("mem_rdy0", {15'd0, ready}, 16'd1);
      chk("mem_busy0", {15'd0, mem_busy}, 16'd0);
      chk("m1_rdy0", {15'd0, m1_ready}, 16'd1);
      nxt(); drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1); neg();
      chk("mem_stall1", {15'd0, stall}, 16'd1);
      chk("mem_busy1", {15'd0, mem_busy}, 16'd1);
      chk("mem_rdy1", {15'd0, ready}, 16'd0);
      chk("m1_rdy1", {15'd0, m1_ready}, 16'd1);
      chk("m1_stall1", {15'd0, m1_stall}, 16'd0);
      chk("m1_busy1", {15'd0, m1_busy}, 16'd0);
      nxt(); neg();
      chk("mem_rdy2", {15'd0, ready}, 16'd1);
      chk("mem_busy2", {15'd0, mem_busy}, 16'd0);
      chk("mem_hcnt", hcnt, 16'd7);
      nxt(); idle(); m1_valid = 1'b0; m1_memen = 1'b0; neg();
      chk("mem_busy3", {15'd0, mem_busy}, 16'd1);
      chk("m1_hcnt", m1_hcnt, 16'd0);
      nxt(); neg();
      chk("mem_busy4", {15'd0, mem_busy}, 16'd0);
      nxt();

      // Halt with r11 and r12 in flight; the waiting op reads r11
      drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd11, 0);
      nxt(); drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd12, 0);
      nxt(); halt = 1'b1; drive(1, 1, 0, 1, 5'd11, 5'd0, 5'd13, 0); neg();
      chk("halt_rdy0", {15'd0, ready}, 16'd0);
      chk("halt_st0", {15'd0, stall}, 16'd1);
      chk("halt_issue0", {15'd0, issue}, 16'd1);
      nxt(); neg();
      chk("halt_st1", {15'd0, stall}, 16'd1);
      chk("halt_wbv1", {15'd0, wb_valid}, 16'd1);
      chk("halt_wba1", {11'd0, wb_addr}, 16'd11);
      nxt(); neg();
      chk("halt_st2", {15'd0, stall}, 16'd0);
      chk("halt_rdy2", {15'd0, ready}, 16'd0);
      chk("halt_wbv2", {15'd0, wb_valid}, 16'd1);
      chk("halt_wba2", {11'd0, wb_addr}, 16'd12);
      nxt(); neg();
      chk("halt_wbv3", {15'd0, wb_valid}, 16'd0);
      chk("halt_issue3", {15'd0, issue}, 16'd0);
      nxt(); halt = 1'b0; neg();
      chk("halt_resume", {15'd0, ready}, 16'd1);
      chk("halt_hcnt", hcnt, 16'd9);
      nxt(); idle(); neg();
      chk("halt_issue5", {15'd0, issue}, 16'd1);
      repeat (4) nxt();

      // Asynchronous reset with three valid entries and the memory port busy
      drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd20, 0);
      nxt(); drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd21, 0);
      nxt(); drive(1, 0, 0, 1, 5'd0, 5'd0, 5'd22, 1);
      nxt(); idle(); #1;
      chk("pre_wbv", {15'd0, wb_valid}, 16'd1);
      chk("pre_wba", {11'd0, wb_addr}, 16'd20);
      chk("pre_busy", {15'd0, mem_busy}, 16'd1);
      chk("pre_hcnt", hcnt, 16'd9);
      reset = 1'b0; #1;
      chk("arst_wbv", {15'd0, wb_valid}, 16'd0);
      chk("arst_issue", {15'd0, issue}, 16'd0);
      chk("arst_busy", {15'd0, mem_busy}, 16'd0);
      chk("arst_hcnt", hcnt, 16'd0);
      chk("arst_wba", {11'd0, wb_addr}, 16'd0);
      reset = 1'b1; #1;
      drive(1, 1, 1, 1, 5'd22, 5'd21, 5'd1, 1); neg();
      chk("post_stall", {15'd0, stall}, 16'd0);
      chk("post_rdy", {15'd0, ready}, 16'd1);
      nxt(); idle(); neg();
      chk("post_issue", {15'd0, issue}, 16'd1);

      // Let the saturation instance pass 65535 stall cycles, then hold
      repeat (71000) nxt();
      neg();
      chk("sat_ffff", s_hcnt, 16'hFFFF);
      repeat (40) nxt();
      neg();
      chk("sat_hold", s_hcnt, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
